// File: rtl/rank_filter_stream_ctrl.sv
// Streams NUM_SAMPLES samples from an input ROM through an external rank-order
// filter core and writes each filtered result to an output RAM, with start/done
// handshaking, filter-latency compensation, single-step mode and result browsing.
module rank_filter_stream_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int NUM_SAMPLES = 255,
  parameter int ADDR_BITS   = 8,
  parameter int FILT_LAT    = 1,
  parameter int CNT_BITS    = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 browse_up,
  input  logic                 browse_down,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_BITS-1:0] rom_data,
  output logic                 filt_clr,
  output logic                 filt_en,
  output logic [DATA_BITS-1:0] filt_in,
  input  logic [DATA_BITS-1:0] filt_out,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic [ADDR_BITS-1:0] ram_raddr,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_BITS-1:0]  sample_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [CNT_BITS-1:0]  LAST_IDX  = CNT_BITS'(NUM_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SAMPLES - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   wr_ptr;
  logic [FILT_LAT:0]     valid_pipe;
  logic [ADDR_BITS-1:0]  browse_addr;
  logic                  issue;
  logic                  write;

  // Bit 0 marks the cycle the ROM data reaches the filter; the tail bit marks
  // the cycle the filter result for that sample is valid and gets written.
  assign write = valid_pipe[FILT_LAT];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the state-derived control outputs.
  always_comb begin
    state_next = state;
    filt_clr   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        filt_clr   = 1'b1;
        busy       = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        issue = !step_mode || step;
        if (issue && rd_ptr == LAST_IDX) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (write && wr_ptr == LAST_IDX) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_CLEAR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read/write pointers and the issue-valid pipeline that covers ROM plus filter latency.
  always_ff @(posedge clk) begin
    if (rst || state == ST_CLEAR) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      valid_pipe <= '0;
    end else begin
      valid_pipe <= {valid_pipe[FILT_LAT-1:0], issue};
      if (issue) rd_ptr <= rd_ptr + CNT_BITS'(1);
      if (write) wr_ptr <= wr_ptr + CNT_BITS'(1);
    end
  end

  // Result browse pointer, wrapping within the populated RAM range.
  always_ff @(posedge clk) begin
    if (rst) begin
      browse_addr <= '0;
    end else if (browse_up && !browse_down) begin
      browse_addr <= (browse_addr == LAST_ADDR) ? '0 : browse_addr + ADDR_BITS'(1);
    end else if (browse_down && !browse_up) begin
      browse_addr <= (browse_addr == '0) ? LAST_ADDR : browse_addr - ADDR_BITS'(1);
    end
  end

  assign rom_addr     = ADDR_BITS'(rd_ptr);
  assign filt_en      = valid_pipe[0];
  assign filt_in      = valid_pipe[0] ? rom_data : '0;
  assign ram_we       = write;
  assign ram_waddr    = ADDR_BITS'(wr_ptr);
  assign ram_wdata    = write ? filt_out : '0;
  assign ram_raddr    = browse_addr;
  assign sample_count = wr_ptr;

endmodule
